// File: rtl/prog_pkt_rx_pkg.sv
// Shared constants and state type for the program-packet receiver.
package prog_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_PROG  = 8'h01;
    localparam logic [7:0] CMD_EXIT  = 8'h02;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } prog_rx_state_t;

endpackage

// File: rtl/prog_pkt_rx.sv
// Parses SYNC/CMD/payload/CHK packets from the UART byte stream and commits
// the latest accepted payload to the renderer only at a frame boundary.
module prog_pkt_rx
    import prog_pkt_pkg::*;
#(
    parameter int PROG_PAYLD_PKT_BITS = 48,
    parameter int TIMEOUT_CYCLES      = 1_000_000
) (
    input  logic                           clk_pix,
    input  logic                           rst_pix,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    input  logic                           frame_start,
    output logic [PROG_PAYLD_PKT_BITS-1:0] prog_buffer,
    output logic                           is_sym_mode,
    output logic                           pkt_ok,
    output logic                           pkt_err
);

    localparam int N     = PROG_PAYLD_PKT_BITS / 8;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    if ((PROG_PAYLD_PKT_BITS % 8) != 0 || PROG_PAYLD_PKT_BITS == 0) begin : g_bad_width
        $error("prog_pkt_rx: PROG_PAYLD_PKT_BITS must be a non-zero multiple of 8");
    end

    prog_rx_state_t                 state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [7:0]                     xor_q, xor_d;
    logic [GAP_W-1:0]               gap_q, gap_d;
    logic                           is_prog_q, is_prog_d;
    logic [PROG_PAYLD_PKT_BITS-1:0] shadow_next_q, shadow_next_d;
    logic [PROG_PAYLD_PKT_BITS-1:0] shadow_q, shadow_d;
    logic                           shadow_mode_q, shadow_mode_d;
    logic                           pending_q, pending_d;
    logic [PROG_PAYLD_PKT_BITS-1:0] prog_buffer_q, prog_buffer_d;
    logic                           is_sym_mode_q, is_sym_mode_d;
    logic                           pkt_ok_q, pkt_ok_d;
    logic                           pkt_err_q, pkt_err_d;
    logic                           accept_s;
    logic                           timeout_s;

    // Packet parser, gap timer, shadow update and frame-boundary commit.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        xor_d         = xor_q;
        is_prog_d     = is_prog_q;
        shadow_next_d = shadow_next_q;
        shadow_d      = shadow_q;
        shadow_mode_d = shadow_mode_q;
        pending_d     = pending_q;
        prog_buffer_d = prog_buffer_q;
        is_sym_mode_d = is_sym_mode_q;
        pkt_ok_d      = 1'b0;
        pkt_err_d     = 1'b0;
        accept_s      = 1'b0;

        if (state_q == IDLE || rx_valid) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q + GAP_W'(1);
        end

        // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a packet.
        timeout_s = (state_q != IDLE) && !rx_valid &&
                    (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

        if (timeout_s) begin
            state_d   = IDLE;
            pkt_err_d = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = CMD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CMD: begin
                    if (rx_data == CMD_PROG) begin
                        state_d   = PAYLOAD;
                        idx_d     = '0;
                        xor_d     = CMD_PROG;
                        is_prog_d = 1'b1;
                    end else if (rx_data == CMD_EXIT) begin
                        state_d   = CHECK;
                        xor_d     = CMD_EXIT;
                        is_prog_d = 1'b0;
                    end else begin
                        state_d   = IDLE;
                        pkt_err_d = 1'b1;
                    end
                end
                PAYLOAD: begin
                    shadow_next_d[{idx_q, 3'b000} +: 8] = rx_data;
                    xor_d = xor_q ^ rx_data;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_d = CHECK;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                CHECK: begin
                    state_d = IDLE;
                    if (rx_data == xor_q) begin
                        accept_s = 1'b1;
                        pkt_ok_d = 1'b1;
                    end else begin
                        pkt_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Commit reads the pre-edge shadow, so a same-cycle accept waits a frame.
        if (frame_start && pending_q) begin
            if (shadow_mode_q) begin
                prog_buffer_d = shadow_q;
            end else begin
                prog_buffer_d = prog_buffer_q;
            end
            is_sym_mode_d = shadow_mode_q;
            pending_d     = 1'b0;
        end else begin
            is_sym_mode_d = is_sym_mode_q;
        end

        if (accept_s) begin
            if (is_prog_q) begin
                shadow_d = shadow_next_q;
            end else begin
                shadow_d = shadow_q;
            end
            shadow_mode_d = is_prog_q;
            pending_d     = 1'b1;
        end else begin
            shadow_mode_d = shadow_mode_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            xor_q         <= 8'h00;
            gap_q         <= '0;
            is_prog_q     <= 1'b0;
            shadow_next_q <= '0;
            shadow_q      <= '0;
            shadow_mode_q <= 1'b0;
            pending_q     <= 1'b0;
            prog_buffer_q <= '0;
            is_sym_mode_q <= 1'b0;
            pkt_ok_q      <= 1'b0;
            pkt_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            xor_q         <= xor_d;
            gap_q         <= gap_d;
            is_prog_q     <= is_prog_d;
            shadow_next_q <= shadow_next_d;
            shadow_q      <= shadow_d;
            shadow_mode_q <= shadow_mode_d;
            pending_q     <= pending_d;
            prog_buffer_q <= prog_buffer_d;
            is_sym_mode_q <= is_sym_mode_d;
            pkt_ok_q      <= pkt_ok_d;
            pkt_err_q     <= pkt_err_d;
        end
    end

    assign prog_buffer = prog_buffer_q;
    assign is_sym_mode = is_sym_mode_q;
    assign pkt_ok      = pkt_ok_q;
    assign pkt_err     = pkt_err_q;

endmodule

// File: tb/tb_prog_pkt_rx.sv
// Directed bench for prog_pkt_rx: a packet-level reference model is checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_prog_pkt_rx;

    localparam int BITS = 48;
    localparam int N    = BITS / 8;
    localparam int TMO  = 16;

    logic            clk_pix = 1'b0;
    logic            rst_pix = 1'b1;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic            frame_start = 1'b0;
    logic [BITS-1:0] prog_buffer;
    logic            is_sym_mode;
    logic            pkt_ok;
    logic            pkt_err;

    prog_pkt_rx #(.PROG_PAYLD_PKT_BITS(BITS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_start (frame_start),
        .prog_buffer (prog_buffer),
        .is_sym_mode (is_sym_mode),
        .pkt_ok      (pkt_ok),
        .pkt_err     (pkt_err)
    );

    always #5 clk_pix = ~clk_pix;

    int n_checks = 0;
    int n_errors = 0;
    int ok_cnt   = 0;
    int err_cnt  = 0;

    task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs captured at the active edge; the model consumes them on the next negedge.
    logic       c_tick = 1'b0;
    logic       c_rst, c_v, c_fs;
    logic [7:0] c_d;
    always @(posedge clk_pix) begin
        c_rst  <= rst_pix;
        c_v    <= rx_valid;
        c_d    <= rx_data;
        c_fs   <= frame_start;
        c_tick <= 1'b1;
    end

    // Reference model: packet bytes collected in a queue, judged when complete.
    logic [7:0]      pk[$];
    bit              m_in, m_live, m_mode, m_sym, m_pend, m_ok, m_err;
    int              m_idle;
    logic [BITS-1:0] m_shadow, m_buf;

    task automatic model_step();
        bit         acc;
        logic [7:0] x;
        logic [BITS-1:0] pay;
        acc   = 1'b0;
        m_ok  = 1'b0;
        m_err = 1'b0;
        if (c_rst) begin
            m_in = 1'b0; pk.delete(); m_idle = 0; m_shadow = '0; m_buf = '0;
            m_mode = 1'b0; m_sym = 1'b0; m_pend = 1'b0; m_live = 1'b1;
        end else begin
            if (c_v) begin
                m_idle = 0;
                if (!m_in) begin
                    if (c_d == 8'hA5) begin
                        m_in = 1'b1;
                        pk.delete();
                    end
                end else begin
                    pk.push_back(c_d);
                    if (pk.size() == 1 && pk[0] != 8'h01 && pk[0] != 8'h02) begin
                        m_err = 1'b1; m_in = 1'b0;
                    end else if (pk.size() == ((pk[0] == 8'h01) ? N + 2 : 2)) begin
                        x = 8'h00;
                        for (int i = 0; i < pk.size() - 1; i++) x = x ^ pk[i];
                        if (x == pk[pk.size()-1]) acc = 1'b1;
                        else m_err = 1'b1;
                        m_in = 1'b0;
                    end
                end
            end else if (m_in) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_err = 1'b1; m_in = 1'b0; m_idle = 0;
                end
            end
            if (c_fs && m_pend) begin
                if (m_mode) m_buf = m_shadow;
                m_sym  = m_mode;
                m_pend = 1'b0;
            end
            if (acc) begin
                if (pk[0] == 8'h01) begin
                    pay = '0;
                    for (int i = 0; i < N; i++) pay[8*i +: 8] = pk[1+i];
                    m_shadow = pay;
                end
                m_mode = (pk[0] == 8'h01);
                m_pend = 1'b1;
                m_ok   = 1'b1;
            end
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk_pix) begin
        if (c_tick) begin
            model_step();
            if (m_live) begin
                chk("prog_buffer", prog_buffer, m_buf);
                chk("is_sym_mode", {47'd0, is_sym_mode}, {47'd0, m_sym});
                chk("pkt_ok", {47'd0, pkt_ok}, {47'd0, m_ok});
                chk("pkt_err", {47'd0, pkt_err}, {47'd0, m_err});
                chk("ok_err_excl", {47'd0, pkt_ok & pkt_err}, 48'd0);
                if (pkt_ok === 1'b1) ok_cnt++;
                if (pkt_err === 1'b1) err_cnt++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic fs);
        @(negedge clk_pix);
        rx_valid    = 1'b1;
        rx_data     = b;
        frame_start = fs;
        @(negedge clk_pix);
        rx_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_prog(input logic [47:0] pay, input logic [7:0] c, input logic fs_on_chk);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < N; i++) send_byte(pay[8*i +: 8], 1'b0);
        send_byte(c, fs_on_chk);
    endtask

    task automatic pulse_fs();
        @(negedge clk_pix);
        frame_start = 1'b1;
        @(negedge clk_pix);
        frame_start = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_pix);
        #1;
    endtask

    int ok0, err0, got;

    initial begin
        repeat (3) @(negedge clk_pix);
        rst_pix = 1'b0;
        idle(2);
        chk("rst_buf", prog_buffer, 48'd0);
        chk("rst_sym", {47'd0, is_sym_mode}, 48'd0);
        chk("rst_ok_err", {46'd0, pkt_ok, pkt_err}, 48'd0);

        // Valid PROG packet; outputs hold until frame_start.
        ok0 = ok_cnt; err0 = err_cnt;
        send_prog(48'h000F_0040_0020, 8'h6E, 1'b0);
        idle(3);
        chk("t1_ok_once", 48'(ok_cnt - ok0), 48'd1);
        chk("t1_no_err", 48'(err_cnt - err0), 48'd0);
        chk("t1_hold", prog_buffer, 48'd0);
        pulse_fs();
        chk("t1_buf", prog_buffer, 48'h000F_0040_0020);
        chk("t1_sym", {47'd0, is_sym_mode}, 48'd1);
        chk("t1_model_buf", m_buf, 48'h000F_0040_0020);

        // Bad checksum.
        ok0 = ok_cnt; err0 = err_cnt;
        send_prog(48'h000F_0040_0020, 8'h6F, 1'b0);
        idle(3);
        chk("t2_err", 48'(err_cnt - err0), 48'd1);
        chk("t2_no_ok", 48'(ok_cnt - ok0), 48'd0);
        pulse_fs();
        chk("t2_buf", prog_buffer, 48'h000F_0040_0020);
        chk("t2_sym", {47'd0, is_sym_mode}, 48'd1);

        // EXIT keeps the buffer and clears symbol mode.
        ok0 = ok_cnt;
        send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h02, 1'b0);
        idle(3);
        chk("t3_ok", 48'(ok_cnt - ok0), 48'd1);
        pulse_fs();
        chk("t3_sym", {47'd0, is_sym_mode}, 48'd0);
        chk("t3_buf", prog_buffer, 48'h000F_0040_0020);
        chk("t3_model_sym", {47'd0, m_sym}, 48'd0);

        // Two accepts before one frame_start: latest wins, single commit.
        ok0 = ok_cnt;
        send_prog(48'h000F_0040_0030, 8'h7E, 1'b0);
        send_prog(48'h000F_0040_0010, 8'h5E, 1'b0);
        idle(3);
        chk("t4_ok2", 48'(ok_cnt - ok0), 48'd2);
        pulse_fs();
        chk("t4_buf", prog_buffer, 48'h000F_0040_0010);
        chk("t4_lo16", {32'd0, prog_buffer[15:0]}, 48'h0010);
        chk("t4_sym", {47'd0, is_sym_mode}, 48'd1);
        pulse_fs();
        chk("t4_buf_again", prog_buffer, 48'h000F_0040_0010);

        // Junk, unknown CMD, then a stalled packet that times out.
        err0 = err_cnt;
        send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0);
        idle(3);
        chk("t5_junk", 48'(err_cnt - err0), 48'd0);
        send_byte(8'hA5, 1'b0); send_byte(8'h07, 1'b0);
        idle(3);
        chk("t5_badcmd", 48'(err_cnt - err0), 48'd1);
        send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h40, 1'b0);
        got = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_pix);
            if (pkt_err === 1'b1) begin
                got = k;
                break;
            end
        end
        chk("t5_timeout_cycle", 48'(got), 48'd16);
        ok0 = ok_cnt;
        send_prog(48'h000F_0040_0020, 8'h6E, 1'b0);
        idle(3);
        chk("t5_after_ok", 48'(ok_cnt - ok0), 48'd1);
        pulse_fs();
        chk("t5_buf", prog_buffer, 48'h000F_0040_0020);

        // Reset mid-payload, then an accept coinciding with frame_start.
        send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
        @(negedge clk_pix);
        rst_pix = 1'b1;
        idle(2);
        rst_pix = 1'b0;
        idle(1);
        chk("t6_rst_buf", prog_buffer, 48'd0);
        send_prog(48'h6655_4433_2211, 8'h76, 1'b1);
        idle(3);
        chk("t6_no_commit", prog_buffer, 48'd0);
        chk("t6_sym0", {47'd0, is_sym_mode}, 48'd0);
        pulse_fs();
        chk("t6_buf", prog_buffer, 48'h6655_4433_2211);
        chk("t6_sym", {47'd0, is_sym_mode}, 48'd1);
        chk("t6_model_buf", m_buf, 48'h6655_4433_2211);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
